// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
package mult_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ADDST,
    S_SHIFT,
    S_DONE,
    S_WAITREL
  } mult_state_t;

  // Width of a counter that must hold values 0..width inclusive.
  function automatic int unsigned step_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake/control bundle between the multiplier controller and its datapath.
interface mult_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  import mult_seq_ctrl_pkg::*;

  localparam int unsigned CW = step_cnt_w(WIDTH);

  logic          Run;
  logic          ClearA_LoadB;
  logic          Signed;
  logic          MBit;
  logic          ADD;
  logic          SUB;
  logic          SHIFTXAB;
  logic          ClearXA;
  logic          LoadB;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] StepCnt;

  modport slave (
    input  Run, ClearA_LoadB, Signed, MBit,
    output ADD, SUB, SHIFTXAB, ClearXA, LoadB, Busy, Done, StepCnt
  );

  modport master (
    output Run, ClearA_LoadB, Signed, MBit,
    input  ADD, SUB, SHIFTXAB, ClearXA, LoadB, Busy, Done, StepCnt
  );

endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the X:A:B shift-add multiplier: clear, WIDTH add/sub+shift steps, done.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input logic             Clk,
  input logic             Reset_n,
  mult_seq_ctrl_if.slave  bus
);

  localparam int unsigned   CW   = step_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t   r_state;
  mult_state_t   w_next;
  logic [CW-1:0] r_step_cnt;
  logic          r_signed;

  logic w_start;
  logic w_inc;
  logic w_last;
  logic w_add, w_sub, w_shift, w_clear_xa, w_load_b, w_busy, w_done;

  assign w_last = (r_step_cnt == LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_step_cnt <= '0;
      r_signed   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_step_cnt <= '0;
        r_signed   <= bus.Signed;
      end else if (w_inc) begin
        r_step_cnt <= r_step_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_inc      = 1'b0;
    w_add      = 1'b0;
    w_sub      = 1'b0;
    w_shift    = 1'b0;
    w_clear_xa = 1'b0;
    w_load_b   = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_load_b   = bus.ClearA_LoadB;
        w_clear_xa = bus.ClearA_LoadB;
        if (!bus.ClearA_LoadB && bus.Run) begin
          w_next  = S_CLEAR;
          w_start = 1'b1;
        end
      end
      S_CLEAR: begin
        w_busy     = 1'b1;
        w_clear_xa = 1'b1;
        w_next     = S_ADDST;
      end
      S_ADDST: begin
        w_busy = 1'b1;
        // Final step of a signed multiply subtracts the multiplicand (sign weight of B).
        w_sub  = bus.MBit & w_last & r_signed;
        w_add  = bus.MBit & ~w_sub;
        if (SKIP_ZERO && !bus.MBit) begin
          w_shift = 1'b1;
          w_inc   = 1'b1;
          w_next  = w_last ? S_DONE : S_ADDST;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy  = 1'b1;
        w_shift = 1'b1;
        w_inc   = 1'b1;
        w_next  = w_last ? S_DONE : S_ADDST;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_WAITREL;
      end
      S_WAITREL: begin
        if (!bus.Run) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.ADD      = w_add;
  assign bus.SUB      = w_sub;
  assign bus.SHIFTXAB = w_shift;
  assign bus.ClearXA  = w_clear_xa;
  assign bus.LoadB    = w_load_b;
  assign bus.Busy     = w_busy;
  assign bus.Done     = w_done;
  assign bus.StepCnt  = r_step_cnt;

endmodule
